// File: rtl/gals_req_arbiter.sv
// Round-robin arbiter granting one shared resource to N_REQ 4-phase level requesters.
// Each request is synchronized, edge-detected, latched as pending and served start/done/return-to-zero.
module gals_req_arbiter #(
    parameter int N_REQ    = 4,
    parameter int SYNC_STG = 1,
    parameter int IDX_W    = $clog2(N_REQ),
    parameter int TIMEOUT  = 1024,
    parameter int TO_W     = $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic             res_start,
    output logic [IDX_W-1:0] res_sel,
    input  logic             res_done,
    output logic             busy,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

    state_t                        state;
    logic [N_REQ-1:0][SYNC_STG:0]  dly;
    logic [N_REQ-1:0]              rise;
    logic [N_REQ-1:0]              req_s;
    logic [N_REQ-1:0]              pending;
    logic [IDX_W-1:0]              ptr;
    logic [TO_W-1:0]               wd;
    logic                          win_vld;
    logic [IDX_W-1:0]              win_idx;
    logic [N_REQ-1:0]              win_oh;

    for (genvar k = 0; k < N_REQ; k++) begin : g_sync
        // NOTE: sequential state is updated with non-blocking assignments only, so every
        // flop samples the pre-edge value of its neighbour and the chain shifts one stage per edge.
        always_ff @(posedge clk) begin
            if (rst) begin
                dly[k] <= '0;
            end else if (SYNC_STG == 0) begin
                dly[k] <= req[k];
            end else begin
                dly[k] <= {dly[k][SYNC_STG-1:0], req[k]};
            end
        end

        if (SYNC_STG == 0) begin : g_raw
            assign rise[k] = req[k] & ~dly[k][0];
        end else begin : g_chain
            assign rise[k] = dly[k][SYNC_STG-1] & ~dly[k][SYNC_STG];
        end

        assign req_s[k] = dly[k][SYNC_STG];
    end

    function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int off);
        int j;
        j = int'(base) + off;
        if (j >= N_REQ) j = j - N_REQ;
        return IDX_W'(j);
    endfunction

    // Scanning from the farthest offset down lets the nearest pending index at/after ptr win.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (pending[rr_idx(ptr, i)]) begin
                win_vld = 1'b1;
                win_idx = rr_idx(ptr, i);
            end
        end
    end

    assign win_oh = (state == IDLE && win_vld) ? (N_REQ'(1) << win_idx) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= '0;
            ptr       <= '0;
            wd        <= '0;
            gnt       <= '0;
            res_start <= 1'b0;
            res_sel   <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            res_start <= 1'b0;
            err       <= 1'b0;
            // A rise in the same cycle as its grant wins, so it is never dropped.
            pending   <= (pending & ~win_oh) | rise;

            case (state)
                IDLE: begin
                    if (win_vld) begin
                        state     <= BUSY;
                        gnt       <= win_oh;
                        res_sel   <= win_idx;
                        busy      <= 1'b1;
                        res_start <= 1'b1;
                        wd        <= '0;
                    end
                end

                BUSY: begin
                    if (res_done) begin
                        state <= RELEASE;
                        gnt   <= '0;
                    end else if (wd == TO_W'(TIMEOUT - 1)) begin
                        state <= RELEASE;
                        gnt   <= '0;
                        err   <= 1'b1;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end

                RELEASE: begin
                    // Hold off the next grant until the served requester has returned to zero.
                    if (!req_s[res_sel]) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        ptr   <= (res_sel == IDX_W'(N_REQ - 1)) ? '0 : res_sel + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gals_req_arbiter.sv
// Directed bench for gals_req_arbiter: a cycle-by-cycle vector table plus hand sequences
// for watchdog expiry, done/expiry coincidence, held request and reset mid-grant.
module tb_gals_req_arbiter;

    localparam int N_REQ   = 4;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       res_start;
    logic [1:0] res_sel;
    logic       res_done;
    logic       busy;
    logic       err;

    int checks   = 0;
    int failures = 0;

    gals_req_arbiter #(
        .N_REQ    (N_REQ),
        .SYNC_STG (1),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .res_start (res_start),
        .res_sel   (res_sel),
        .res_done  (res_done),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       done;
        logic [3:0] gnt;
        logic       start;
        logic [1:0] sel;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [3:0] q, input logic d,
                       input logic [3:0] g, input logic s, input logic [1:0] sl, input logic b);
        vec_t v;
        v.rst = r; v.req = q; v.done = d; v.gnt = g; v.start = s; v.sel = sl; v.busy = b;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
    task automatic tick(input logic r, input logic [3:0] q, input logic d);
        @(negedge clk);
        rst      = r;
        req      = q;
        res_done = d;
        @(posedge clk);
        #1;
        check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    endtask

    initial begin
        int n;
        rst = 1'b1; req = '0; res_done = 1'b0;

        // single request to 2, pointer ends at 3
        add(1, 4'b0000, 0, 4'b0000, 0, 0, 0);
        add(0, 4'b0100, 0, 4'b0000, 0, 0, 0);
        add(0, 4'b0100, 0, 4'b0000, 0, 0, 0);
        add(0, 4'b0100, 0, 4'b0100, 1, 2, 1);
        add(0, 4'b0100, 0, 4'b0100, 0, 2, 1);
        add(0, 4'b0100, 1, 4'b0000, 0, 2, 1);
        add(0, 4'b0000, 0, 4'b0000, 0, 2, 1);
        add(0, 4'b0000, 0, 4'b0000, 0, 2, 1);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0);
        // wrap: pointer 3, pending {0,3} -> 3 then 0 after a single IDLE cycle
        add(0, 4'b1001, 0, 4'b0000, 0, 0, 0);
        add(0, 4'b1001, 0, 4'b0000, 0, 0, 0);
        add(0, 4'b1001, 0, 4'b1000, 1, 3, 1);
        add(0, 4'b1001, 1, 4'b0000, 0, 3, 1);
        add(0, 4'b0001, 0, 4'b0000, 0, 3, 1);
        add(0, 4'b0001, 0, 4'b0000, 0, 3, 1);
        add(0, 4'b0001, 0, 4'b0000, 0, 0, 0);
        add(0, 4'b0001, 0, 4'b0001, 1, 0, 1);
        add(0, 4'b0001, 1, 4'b0000, 0, 0, 1);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 1);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 1);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0);
        // reset, then simultaneous 1011 -> 0,1,3
        add(1, 4'b0000, 0, 4'b0000, 0, 0, 0);
        add(0, 4'b1011, 0, 4'b0000, 0, 0, 0);
        add(0, 4'b1011, 0, 4'b0000, 0, 0, 0);
        add(0, 4'b1011, 0, 4'b0001, 1, 0, 1);
        add(0, 4'b1011, 1, 4'b0000, 0, 0, 1);
        add(0, 4'b1010, 0, 4'b0000, 0, 0, 1);
        add(0, 4'b1010, 0, 4'b0000, 0, 0, 1);
        add(0, 4'b1010, 0, 4'b0000, 0, 0, 0);
        add(0, 4'b1010, 0, 4'b0010, 1, 1, 1);
        add(0, 4'b1010, 1, 4'b0000, 0, 1, 1);
        add(0, 4'b1000, 0, 4'b0000, 0, 1, 1);
        add(0, 4'b1000, 0, 4'b0000, 0, 1, 1);
        add(0, 4'b1000, 0, 4'b0000, 0, 0, 0);
        add(0, 4'b1000, 0, 4'b1000, 1, 3, 1);
        add(0, 4'b1000, 1, 4'b0000, 0, 3, 1);
        add(0, 4'b0000, 0, 4'b0000, 0, 3, 1);
        add(0, 4'b0000, 0, 4'b0000, 0, 3, 1);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0);
        // res_done while idle is ignored
        add(0, 4'b0000, 1, 4'b0000, 0, 0, 0);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0);

        foreach (vecs[i]) begin
            tick(vecs[i].rst, vecs[i].req, vecs[i].done);
            check($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
            check($sformatf("v%0d_start", i), 32'(res_start), 32'(vecs[i].start));
            check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
            check($sformatf("v%0d_err", i), 32'(err), 32'd0);
            if (vecs[i].busy)
                check($sformatf("v%0d_sel", i), 32'(res_sel), 32'(vecs[i].sel));
        end

        // watchdog: grant 0 never completes, err exactly TIMEOUT cycles after res_start
        tick(0, 4'b0011, 0);
        tick(0, 4'b0011, 0);
        tick(0, 4'b0011, 0);
        check("wd_grant0", 32'(gnt), 32'b0001);
        check("wd_start", 32'(res_start), 32'd1);
        n = 0;
        while (n < 40 && !err) begin
            tick(0, 4'b0011, 0);
            n++;
        end
        check("wd_err_latency", 32'(n), 32'(TIMEOUT));
        check("wd_gnt_drop", 32'(gnt), 32'd0);
        check("wd_busy_hold", 32'(busy), 32'd1);
        tick(0, 4'b0010, 0);
        check("wd_err_pulse", 32'(err), 32'd0);
        check("wd_rel_busy1", 32'(busy), 32'd1);
        tick(0, 4'b0010, 0);
        check("wd_rel_busy2", 32'(busy), 32'd1);
        tick(0, 4'b0010, 0);
        check("wd_idle", 32'(busy), 32'd0);
        tick(0, 4'b0010, 0);
        check("wd_next_gnt", 32'(gnt), 32'b0010);
        check("wd_next_sel", 32'(res_sel), 32'd1);
        check("wd_next_start", 32'(res_start), 32'd1);

        // res_done on the expiry cycle: done wins, no err
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            tick(0, 4'b0010, 0);
            check("co_busy_gnt", 32'(gnt), 32'b0010);
            check("co_no_err", 32'(err), 32'd0);
        end
        tick(0, 4'b0010, 1);
        check("co_gnt_drop", 32'(gnt), 32'd0);
        check("co_err", 32'(err), 32'd0);
        check("co_busy", 32'(busy), 32'd1);
        tick(0, 4'b0010, 0);
        check("co_err_after", 32'(err), 32'd0);

        // req[1] held high: stuck in RELEASE, no new grant
        for (int i = 0; i < 6; i++) begin
            tick(0, 4'b0010, 0);
            check("hold_busy", 32'(busy), 32'd1);
            check("hold_gnt", 32'(gnt), 32'd0);
        end
        tick(0, 4'b0000, 0);
        tick(0, 4'b0000, 0);
        check("hold_rel_busy", 32'(busy), 32'd1);
        tick(0, 4'b0000, 0);
        check("hold_idle", 32'(busy), 32'd0);

        // reset at cycle 5 of a grant to 2 while 3 is pending
        tick(0, 4'b1100, 0);
        tick(0, 4'b1100, 0);
        tick(0, 4'b1100, 0);
        check("rst_grant2", 32'(gnt), 32'b0100);
        for (int i = 0; i < 4; i++) tick(0, 4'b1100, 0);
        check("rst_pre_gnt", 32'(gnt), 32'b0100);
        tick(1, 4'b0000, 0);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_start", 32'(res_start), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick(0, 4'b0000, 0);
            check("rst_pend_clr", 32'(busy), 32'd0);
        end
        tick(0, 4'b1010, 0);
        tick(0, 4'b1010, 0);
        check("rst_no_early", 32'(gnt), 32'd0);
        tick(0, 4'b1010, 0);
        check("rst_ptr0_gnt", 32'(gnt), 32'b0010);
        check("rst_ptr0_sel", 32'(res_sel), 32'd1);
        check("rst_ptr0_start", 32'(res_start), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
